rgb_frame_assembler: RTL and testbench
======================================

# rgb_frame_assembler

Sits between the UART receiver and the image frame buffer in the image-processing top. It takes the receiver's one-byte-per-pulse stream, parses a 4-byte frame header (width, height), and groups the following bytes into R,G,B triples. Each triple is converted to an 8-bit grayscale pixel, which is emitted with its linear row-major frame-buffer address for the edge-detection stage. It also detects malformed headers and stalled transfers, and recovers to header hunting without needing a reset.

## Interface

- MAX_WIDTH, 768, largest accepted frame width in pixels
- MAX_HEIGHT, 512, largest accepted frame height in pixels
- ADDR_WIDTH, 19, width of pixel address; must satisfy 2^ADDR_WIDTH >= MAX_WIDTH*MAX_HEIGHT
- TIMEOUT_CYCLES, 1_000_000, idle clk cycles between bytes before a partial header or frame is aborted
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  8  byte from uart_receiver (data)
- in_valid  in  1  single-cycle strobe, in_data valid (data_valid)
- pix_valid  out  1  single-cycle strobe, pix_data/pix_addr valid
- pix_data  out  8  grayscale pixel
- pix_addr  out  ADDR_WIDTH  row-major address, y*width + x
- frame_width  out  16  width latched from the last accepted header
- frame_height  out  16  height latched from the last accepted header
- frame_start  out  1  pulse, header accepted
- frame_done  out  1  pulse, coincident with the last pixel's pix_valid
- hdr_error  out  1  pulse, header rejected
- frame_abort  out  1  pulse, timeout fired mid-header or mid-frame
- busy  out  1  high from the first header byte until frame end or abort

## Operation

- States: HDR (collect 4 header bytes), PIX (collect RGB triples), with an internal byte index of 0..3 in HDR and 0..2 in PIX.
- Header format is big-endian: width_hi, width_lo, height_hi, height_lo.
- On the 4th header byte:
  - If width is 0, height is 0, width > MAX_WIDTH, or height > MAX_HEIGHT: pulse hdr_error, keep frame_width and frame_height unchanged, stay in HDR with index 0.
  - Otherwise: latch frame_width and frame_height, pulse frame_start, clear the pixel counter, and go to PIX.
- In PIX, bytes arrive in the order R, G, B. On B, compute Y = (77*R + 150*G + 29*B) >> 8.
  - Use 16-bit unsigned arithmetic. The maximum sum is 65280, so there is no overflow. White maps to 255 and black maps to 0.
- pix_addr is a counter starting at 0 and incrementing after each emitted pixel; there is no multiplier.
- When the emitted pixel is number width*height-1: pulse frame_done with it, then return to HDR with index 0.
- Timeout: an idle counter runs whenever busy=1 and clears on every in_valid. When it reaches TIMEOUT_CYCLES: pulse frame_abort, discard any partial triple or header, return to HDR with index 0, and set busy=0. frame_width and frame_height keep their values.
- If in_valid and the timeout condition occur in the same cycle, in_valid wins: the byte is accepted and the counter clears.
- Outside PIX, no byte ever produces pix_valid.

## Timing

- Reset values: all pulses 0, pix_data 0, pix_addr 0, frame_width 0, frame_height 0, busy 0, state HDR with index 0. Reset is asynchronous and immediate; asserting it mid-frame discards all progress.
- pix_valid, pix_data and pix_addr are registered, appearing the cycle after the in_valid carrying B (latency 1). pix_data and pix_addr hold their values until the next pixel.
- frame_start and hdr_error are asserted the cycle after the 4th header byte's in_valid.
- frame_abort is asserted the cycle after the counter reaches TIMEOUT_CYCLES.
- All pulses are exactly one cycle wide.
- A byte arriving the cycle after frame_done or frame_abort is treated as header byte 0. Back-to-back in_valid on consecutive cycles must be handled.
- busy rises the cycle after the first header byte. It falls the cycle after the final B byte (together with frame_done), or with frame_abort. After a rejected header, busy falls together with hdr_error.

## Test plan

- Send header 00 04 00 02 followed by 24 bytes of 8 triples -> 8 pix_valid pulses with addr 0..7; frame_done coincides with addr 7; frame_width=4, frame_height=2; busy=0 afterwards.
- Send triples FF0000, 00FF00, 0000FF, FFFFFF, 000000 -> pix_data 76, 149, 28, 255, 0.
- Send header 03 01 02 00 (width 769), then 00 02 00 01 and 6 bytes -> first: hdr_error pulse, no pixels, no frame_start. Second: frame accepted, 2 pixels at addr 0 and 1.
- With TIMEOUT_CYCLES=100, send header 00 02 00 01 plus R,G only, then idle -> frame_abort after 100 idle cycles, no pix_valid. A following valid header and 6 bytes yield addr 0 and 1.
- Assert reset after 5 of 8 pixels, then deassert and send a full 4x2 frame -> outputs cleared immediately; new frame addresses start at 0; frame_done at addr 7.
- Send two 2x1 frames with in_valid back-to-back on every cycle -> 4 pixels with addr 0,1,0,1; two frame_done and two frame_start pulses.

Source files
------------

// File: rtl/rgb_frame_assembler.sv
// Parses a 4-byte big-endian (width, height) header from a byte stream, then turns RGB triples
// into grayscale pixels tagged with a row-major frame-buffer address.
module rgb_frame_assembler #(
  parameter int unsigned MAX_WIDTH      = 768,
  parameter int unsigned MAX_HEIGHT     = 512,
  parameter int unsigned ADDR_WIDTH     = 19,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  pix_valid,
  output logic [7:0]            pix_data,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  output logic [15:0]           frame_width,
  output logic [15:0]           frame_height,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic                  hdr_error,
  output logic                  frame_abort,
  output logic                  busy
);

  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {StHdr, StPix} state_e;

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           hdr_q, hdr_d;
  logic [7:0]            r_q, r_d, g_q, g_d;
  logic [15:0]           x_q, x_d, y_q, y_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [IdleW-1:0]      idle_q, idle_d;
  logic                  busy_q, busy_d;
  logic [15:0]           frame_width_q, frame_width_d, frame_height_q, frame_height_d;
  logic                  pix_valid_q, pix_valid_d;
  logic [7:0]            pix_data_q, pix_data_d;
  logic [ADDR_WIDTH-1:0] pix_addr_q, pix_addr_d;
  logic                  frame_start_q, frame_start_d, frame_done_q, frame_done_d;
  logic                  hdr_error_q, hdr_error_d, frame_abort_q, frame_abort_d;

  logic [15:0] new_w, new_h, y_sum;
  logic        hdr_bad, last_pix;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    hdr_d          = hdr_q;
    r_d            = r_q;
    g_d            = g_q;
    x_d            = x_q;
    y_d            = y_q;
    cnt_d          = cnt_q;
    idle_d         = idle_q;
    busy_d         = busy_q;
    frame_width_d  = frame_width_q;
    frame_height_d = frame_height_q;
    pix_valid_d    = 1'b0;
    pix_data_d     = pix_data_q;
    pix_addr_d     = pix_addr_q;
    frame_start_d  = 1'b0;
    frame_done_d   = 1'b0;
    hdr_error_d    = 1'b0;
    frame_abort_d  = 1'b0;

    new_w    = hdr_q[23:8];
    new_h    = {hdr_q[7:0], in_data};
    hdr_bad  = (new_w == 16'd0) || (new_h == 16'd0) ||
               (new_w > 16'(MAX_WIDTH)) || (new_h > 16'(MAX_HEIGHT));
    y_sum    = 16'd77 * {8'd0, r_q} + 16'd150 * {8'd0, g_q} + 16'd29 * {8'd0, in_data};
    // Column/row tracking detects the last pixel without a width*height product.
    last_pix = (x_q == frame_width_q - 16'd1) && (y_q == frame_height_q - 16'd1);

    if (in_valid) begin
      idle_d = '0;
      unique case (state_q)
        StHdr: begin
          busy_d = 1'b1;
          idx_d  = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: hdr_d[23:16] = in_data;
            2'd1: hdr_d[15:8]  = in_data;
            2'd2: hdr_d[7:0]   = in_data;
            2'd3: begin
              idx_d = 2'd0;
              if (hdr_bad) begin
                hdr_error_d = 1'b1;
                busy_d      = 1'b0;
              end else begin
                frame_width_d  = new_w;
                frame_height_d = new_h;
                frame_start_d  = 1'b1;
                cnt_d          = '0;
                x_d            = 16'd0;
                y_d            = 16'd0;
                state_d        = StPix;
              end
            end
          endcase
        end
        StPix: begin
          unique case (idx_q)
            2'd0: begin
              r_d   = in_data;
              idx_d = 2'd1;
            end
            2'd1: begin
              g_d   = in_data;
              idx_d = 2'd2;
            end
            default: begin
              idx_d       = 2'd0;
              pix_valid_d = 1'b1;
              pix_data_d  = y_sum[15:8];
              pix_addr_d  = cnt_q;
              cnt_d       = cnt_q + 1'b1;
              if (x_q == frame_width_q - 16'd1) begin
                x_d = 16'd0;
                y_d = y_q + 16'd1;
              end else begin
                x_d = x_q + 16'd1;
              end
              if (last_pix) begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = StHdr;
              end
            end
          endcase
        end
      endcase
    end else if (busy_q) begin
      if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
        frame_abort_d = 1'b1;
        busy_d        = 1'b0;
        state_d       = StHdr;
        idx_d         = 2'd0;
        idle_d        = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StHdr;
      idx_q          <= 2'd0;
      hdr_q          <= '0;
      r_q            <= '0;
      g_q            <= '0;
      x_q            <= '0;
      y_q            <= '0;
      cnt_q          <= '0;
      idle_q         <= '0;
      busy_q         <= 1'b0;
      frame_width_q  <= '0;
      frame_height_q <= '0;
      pix_valid_q    <= 1'b0;
      pix_data_q     <= '0;
      pix_addr_q     <= '0;
      frame_start_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      hdr_error_q    <= 1'b0;
      frame_abort_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      hdr_q          <= hdr_d;
      r_q            <= r_d;
      g_q            <= g_d;
      x_q            <= x_d;
      y_q            <= y_d;
      cnt_q          <= cnt_d;
      idle_q         <= idle_d;
      busy_q         <= busy_d;
      frame_width_q  <= frame_width_d;
      frame_height_q <= frame_height_d;
      pix_valid_q    <= pix_valid_d;
      pix_data_q     <= pix_data_d;
      pix_addr_q     <= pix_addr_d;
      frame_start_q  <= frame_start_d;
      frame_done_q   <= frame_done_d;
      hdr_error_q    <= hdr_error_d;
      frame_abort_q  <= frame_abort_d;
    end
  end

  assign pix_valid    = pix_valid_q;
  assign pix_data     = pix_data_q;
  assign pix_addr     = pix_addr_q;
  assign frame_width  = frame_width_q;
  assign frame_height = frame_height_q;
  assign frame_start  = frame_start_q;
  assign frame_done   = frame_done_q;
  assign hdr_error    = hdr_error_q;
  assign frame_abort  = frame_abort_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rgb_frame_assembler.sv
// Scoreboard bench for rgb_frame_assembler: directed byte streams push expected pixels into a
// queue; a monitor pops and compares on every pix_valid.
module tb_rgb_frame_assembler;

  localparam int unsigned AW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic [AW-1:0] pix_addr;
  logic [15:0]   frame_width, frame_height;
  logic          frame_start, frame_done, hdr_error, frame_abort, busy;

  rgb_frame_assembler #(
    .MAX_WIDTH     (768),
    .MAX_HEIGHT    (512),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_addr    (pix_addr),
    .frame_width (frame_width),
    .frame_height(frame_height),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .hdr_error   (hdr_error),
    .frame_abort (frame_abort),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         a;
    bit         done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   seen_start = 0, seen_done = 0, seen_err = 0, seen_abort = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: counts pulses and checks every emitted pixel against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_start) seen_start++;
      if (frame_done)  seen_done++;
      if (hdr_error)   seen_err++;
      if (frame_abort) seen_abort++;
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel actual addr=%0d data=%0d required none",
                   pix_addr, pix_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pix_data", int'(pix_data), int'(e.d));
          check("pix_addr", int'(pix_addr), e.a);
          check("frame_done", int'(frame_done), int'(e.done));
          if (e.done) check("busy_at_done", int'(busy), 0);
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL done_without_pixel actual=1 required=0");
      end
    end
  end

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit b2b);
    put(b);
    if (!b2b) gap();
  endtask

  task automatic hdr(input logic [31:0] h, input bit b2b);
    send(h[31:24], b2b);
    send(h[23:16], b2b);
    send(h[15:8], b2b);
    send(h[7:0], b2b);
  endtask

  task automatic triple(input logic [23:0] rgb, input logic [7:0] y, input int a,
                        input bit done, input bit b2b);
    exp_t e;
    send(rgb[23:16], b2b);
    send(rgb[15:8], b2b);
    e.d    = y;
    e.a    = a;
    e.done = done;
    exp_q.push_back(e);
    send(rgb[7:0], b2b);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  logic [23:0] rgb1[8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
                           24'h000000, 24'h102030, 24'h808080, 24'h0A141E};
  logic [7:0]  y1[8]   = '{8'd76, 8'd149, 8'd28, 8'd255, 8'd0, 8'd29, 8'd128, 8'd18};

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_pix_data", int'(pix_data), 0);
    check("rst_pix_addr", int'(pix_addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_width", int'(frame_width), 0);
    check("rst_frame_height", int'(frame_height), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 4x2 frame with the colour test vectors.
    hdr(32'h0004_0002, 1'b0);
    for (int i = 0; i < 8; i++) triple(rgb1[i], y1[i], i, i == 7, 1'b0);
    drain("t1_drain");
    check("t1_starts", seen_start, 1);
    check("t1_dones", seen_done, 1);
    check("t1_width", int'(frame_width), 4);
    check("t1_height", int'(frame_height), 2);
    check("t1_busy_after", int'(busy), 0);

    // Width 769 is rejected; the next 2x1 header is accepted.
    hdr(32'h0301_0200, 1'b0);
    repeat (2) @(negedge clk);
    check("t3_hdr_err", seen_err, 1);
    check("t3_no_start", seen_start, 1);
    check("t3_width_kept", int'(frame_width), 4);
    check("t3_busy_low", int'(busy), 0);
    hdr(32'h0002_0001, 1'b0);
    triple(24'h808080, 8'd128, 0, 1'b0, 1'b0);
    triple(24'hFFFFFF, 8'd255, 1, 1'b1, 1'b0);
    drain("t3_drain");
    check("t3_start", seen_start, 2);
    check("t3_width", int'(frame_width), 2);
    check("t3_height", int'(frame_height), 1);

    // Partial triple then idle: timeout abort.
    hdr(32'h0002_0001, 1'b0);
    send(8'h11, 1'b0);
    put(8'h22);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
      if (frame_abort) break;
    end
    check("t4_abort_latency_ok", int'(n >= 100 && n <= 102), 1);
    repeat (2) @(negedge clk);
    check("t4_aborts", seen_abort, 1);
    check("t4_busy_low", int'(busy), 0);
    check("t4_width_kept", int'(frame_width), 2);
    hdr(32'h0002_0001, 1'b0);
    triple(24'h000000, 8'd0, 0, 1'b0, 1'b0);
    triple(24'h0000FF, 8'd28, 1, 1'b1, 1'b0);
    drain("t4_drain");

    // Reset after 5 of 8 pixels, then a full frame from address 0.
    hdr(32'h0004_0002, 1'b0);
    for (int i = 0; i < 5; i++) triple(rgb1[i], y1[i], i, 1'b0, 1'b0);
    drain("t5_partial_drain");
    check("t5_busy_mid", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_addr", int'(pix_addr), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_width", int'(frame_width), 0);
    check("t5_rst_valid", int'(pix_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    n = seen_done;
    hdr(32'h0004_0002, 1'b0);
    for (int i = 0; i < 8; i++) triple(rgb1[7 - i], y1[7 - i], i, i == 7, 1'b0);
    drain("t5_drain");
    check("t5_done", seen_done - n, 1);

    // Two 2x1 frames, one byte every cycle.
    n = seen_start;
    seen_done = 0;
    hdr(32'h0002_0001, 1'b1);
    triple(24'h102030, 8'd29, 0, 1'b0, 1'b1);
    triple(24'h808080, 8'd128, 1, 1'b1, 1'b1);
    hdr(32'h0002_0001, 1'b1);
    triple(24'hFF0000, 8'd76, 0, 1'b0, 1'b1);
    triple(24'h00FF00, 8'd149, 1, 1'b1, 1'b1);
    gap();
    drain("t6_drain");
    check("t6_starts", seen_start - n, 2);
    check("t6_dones", seen_done, 2);
    check("t6_busy_after", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
